// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  typedef enum logic {DISP, BLANK} state_e;

  function automatic logic [DIGIT_W-1:0] nib_sel(
    input logic [NUM_DIGITS*DIGIT_W-1:0] data,
    input logic [2:0]                    idx
  );
    return data[{idx, 2'b00} +: DIGIT_W];
  endfunction

  // Clear mask bits of leading zero digits (7 down to 1); digit 0 always survives.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [NUM_DIGITS*DIGIT_W-1:0] data,
    input logic [NUM_DIGITS-1:0]         mask
  );
    logic [NUM_DIGITS-1:0] keep;
    logic                  zero_above;
    keep       = '1;
    zero_above = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (data[k*DIGIT_W +: DIGIT_W] == '0);
      if (zero_above) keep[k] = 1'b0;
    end
    return keep & mask;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Frame-write handshake and display drive bundle for seg_scan_ctrl.
interface seg_scan_if;
  import seg_scan_pkg::*;

  logic                          wr_valid;
  logic                          wr_ready;
  logic [NUM_DIGITS*DIGIT_W-1:0] wr_data;
  logic [NUM_DIGITS-1:0]         wr_mask;
  logic [DIGIT_W-1:0]            nibble;
  logic [2:0]                    digit_idx;
  logic [NUM_DIGITS-1:0]         an;
  logic                          frame_tick;

  modport master (
    output wr_valid, wr_data, wr_mask,
    input  wr_ready, nibble, digit_idx, an, frame_tick
  );

  modport slave (
    input  wr_valid, wr_data, wr_mask,
    output wr_ready, nibble, digit_idx, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot counter shared by dwell and blank phases; done_o marks the last cycle of a slot.
module seg_scan_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == limit_i - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (load_i) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller with tear-free frame buffer.
// Optional leading-zero suppression at commit: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 10000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic     clk,
  input  logic     rst,
  seg_scan_if.slave bus
);

  localparam logic [CNT_W-1:0] DWELL_LEN = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LEN = CNT_W'(BLANK_CYCLES);

  state_e                        state_q, state_d;
  logic [2:0]                    digit_q, digit_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] act_data_q, act_data_d, sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]         act_mask_q, act_mask_d, sh_mask_q, sh_mask_d;
  logic                          pending_q, pending_d;
  logic [NUM_DIGITS-1:0]         an_q, an_d;
  logic [DIGIT_W-1:0]            nibble_q, nibble_d;
  logic                          wr_ready_q, wr_ready_d;
  logic                          tick_q, tick_d;

  logic                          slot_done;
  logic [CNT_W-1:0]              slot_len;
  logic                          accept, wrap;
  logic [NUM_DIGITS-1:0]         commit_mask;

  assign slot_len = (state_q == DISP) ? DWELL_LEN : BLANK_LEN;

  seg_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (slot_done),
    .limit_i (slot_len),
    .done_o  (slot_done)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  assign commit_mask = lz_mask(sh_data_q, sh_mask_q);
`else
  assign commit_mask = sh_mask_q;
`endif

  assign accept = bus.wr_valid & wr_ready_q;
  assign wrap   = (state_q == BLANK) & slot_done & (digit_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    act_data_d = act_data_q;
    act_mask_d = act_mask_q;
    sh_data_d  = sh_data_q;
    sh_mask_d  = sh_mask_q;
    pending_d  = pending_q;

    unique case (state_q)
      DISP:  if (slot_done) state_d = BLANK;
      BLANK: if (slot_done) begin
        state_d = DISP;
        digit_d = digit_q + 3'd1;
      end
      default: state_d = DISP;
    endcase

    // accept requires wr_ready, which is low while pending, so it never meets a commit
    if (accept) begin
      sh_data_d = bus.wr_data;
      sh_mask_d = bus.wr_mask;
      pending_d = 1'b1;
    end
    if (wrap && pending_q) begin
      act_data_d = sh_data_q;
      act_mask_d = commit_mask;
      pending_d  = 1'b0;
    end

    // Outputs are registered from next-state so they line up with the state registers.
    an_d = ANODE_OFF;
    if (state_d == DISP && act_mask_d[digit_d]) an_d = ~(NUM_DIGITS'(1) << digit_d);
    nibble_d   = nib_sel(act_data_d, digit_d);
    wr_ready_d = ~pending_d;
    tick_d     = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DISP;
      digit_q    <= '0;
      act_data_q <= '0;
      act_mask_q <= '0;
      sh_data_q  <= '0;
      sh_mask_q  <= '0;
      pending_q  <= 1'b0;
      an_q       <= ANODE_OFF;
      nibble_q   <= '0;
      wr_ready_q <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      sh_data_q  <= sh_data_d;
      sh_mask_q  <= sh_mask_d;
      pending_q  <= pending_d;
      an_q       <= an_d;
      nibble_q   <= nibble_d;
      wr_ready_q <= wr_ready_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.nibble     = nibble_q;
  assign bus.digit_idx  = digit_q;
  assign bus.wr_ready   = wr_ready_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with DWELL=4, BLANK=2 (48-clock frame).
module tb_seg_scan_ctrl;

  localparam int unsigned DW = 4;
  localparam int unsigned BW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BW), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Period index since reset release; period k is sampled on the negedge after k posedges.
  int cyc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] an;
    logic [3:0] nib;
    logic [2:0] dig;
    logic       rdy;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push(input int c, input string nm, input logic [7:0] a, input logic [3:0] n,
                      input logic [2:0] d, input logic r, input logic t);
    exp_t e;
    e.cyc = c; e.name = nm; e.an = a; e.nib = n; e.dig = d; e.rdy = r; e.tick = t;
    q.push_back(e);
  endtask

  function automatic void compare(input exp_t e);
    vectors++;
    if (bus.an !== e.an || bus.nibble !== e.nib || bus.digit_idx !== e.dig ||
        bus.wr_ready !== e.rdy || bus.frame_tick !== e.tick) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got an=%h nib=%h dig=%0d rdy=%b tick=%b exp an=%h nib=%h dig=%0d rdy=%b tick=%b",
               e.name, e.cyc, bus.an, bus.nibble, bus.digit_idx, bus.wr_ready, bus.frame_tick,
               e.an, e.nib, e.dig, e.rdy, e.tick);
    end
  endfunction

  // Monitor: pops expectations as their period comes up.
  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s missed: expected at cyc=%0d, now cyc=%0d", q[0].name, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) compare(q.pop_front());
    end
  end

  task automatic wait_cyc(input int c);
    int unsigned guard = 0;
    while (cyc != c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cyc got cyc=%0d required %0d", cyc, c);
    end
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while (q.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain got %0d pending expectations required 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_now(input string nm);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.an = 8'hFF; e.nib = 4'h0; e.dig = 3'd0; e.rdy = 1'b1; e.tick = 1'b0;
    compare(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_now("rst_state");
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic write_at(input int c, input logic [31:0] d, input logic [7:0] m);
    wait_cyc(c);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_mask  = m;
    wait_cyc(c + 1);
    bus.wr_valid = 1'b0;
  endtask

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_mask  = '0;

    // Idle after reset: blank anodes, digit scan 0..7, single tick at 48.
    do_reset();
    for (int c = 0; c < 96; c++)
      push(c, "idle", 8'hFF, 4'h0, 3'((c / 6) % 8), 1'b1, (c == 48));
    drain();

    // Single write at 5, visible from 48.
    do_reset();
    push(5,  "w_pre",     8'hFF, 4'h0, 3'd0, 1'b1, 1'b0);
    push(6,  "w_busy",    8'hFF, 4'h0, 3'd1, 1'b0, 1'b0);
    push(47, "w_busy_end",8'hFF, 4'h0, 3'd7, 1'b0, 1'b0);
    push(48, "w_tick",    8'hFE, 4'h1, 3'd0, 1'b1, 1'b1);
    push(51, "w_d0_last", 8'hFE, 4'h1, 3'd0, 1'b1, 1'b0);
    push(52, "w_blank0",  8'hFF, 4'h1, 3'd0, 1'b1, 1'b0);
    push(53, "w_blank1",  8'hFF, 4'h1, 3'd0, 1'b1, 1'b0);
    push(54, "w_d1",      8'hFD, 4'h2, 3'd1, 1'b1, 1'b0);
    push(90, "w_d7",      8'h7F, 4'h8, 3'd7, 1'b1, 1'b0);
    write_at(5, 32'h8765_4321, 8'hFF);
    drain();

    // Second write held while pending; accepted at tick, shown one frame later with mask AA.
    do_reset();
    push(10,  "h_ignored", 8'hFF, 4'h0, 3'd1, 1'b0, 1'b0);
    push(47,  "h_busy",    8'hFF, 4'h0, 3'd7, 1'b0, 1'b0);
    push(48,  "h_tick",    8'hFE, 4'h1, 3'd0, 1'b1, 1'b1);
    push(49,  "h_reaccept",8'hFE, 4'h1, 3'd0, 1'b0, 1'b0);
    push(90,  "h_old_d7",  8'h7F, 4'h8, 3'd7, 1'b0, 1'b0);
    push(95,  "h_old_end", 8'hFF, 4'h8, 3'd7, 1'b0, 1'b0);
    push(96,  "m_d0",      8'hFF, 4'h8, 3'd0, 1'b1, 1'b1);
    push(102, "m_d1",      8'hFD, 4'h9, 3'd1, 1'b1, 1'b0);
    push(108, "m_d2",      8'hFF, 4'hA, 3'd2, 1'b1, 1'b0);
    push(114, "m_d3",      8'hF7, 4'hB, 3'd3, 1'b1, 1'b0);
    push(132, "m_d6",      8'hFF, 4'hE, 3'd6, 1'b1, 1'b0);
    push(138, "m_d7",      8'h7F, 4'hF, 3'd7, 1'b1, 1'b0);
    push(144, "m_frame",   8'hFF, 4'h8, 3'd0, 1'b1, 1'b1);
    write_at(5, 32'h8765_4321, 8'hFF);
    wait_cyc(10);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hFEDC_BA98;
    bus.wr_mask  = 8'b1010_1010;
    wait_cyc(49);
    bus.wr_valid = 1'b0;
    drain();

    // Reset during digit 5 DISP with a frame pending; pending frame must never appear.
    do_reset();
    push(48, "r_tick",    8'hFE, 4'h1, 3'd0, 1'b1, 1'b1);
    push(51, "r_pending", 8'hFE, 4'h1, 3'd0, 1'b0, 1'b0);
    push(78, "r_d5",      8'hDF, 4'h6, 3'd5, 1'b0, 1'b0);
    write_at(5, 32'h8765_4321, 8'hFF);
    write_at(50, 32'h1111_1111, 8'h0F);
    wait_cyc(79);
    #1 rst = 1'b1;
    #1 check_now("r_immediate");
    do_reset();
    push(0,  "r_after0",  8'hFF, 4'h0, 3'd0, 1'b1, 1'b0);
    push(6,  "r_after6",  8'hFF, 4'h0, 3'd1, 1'b1, 1'b0);
    push(48, "r_after48", 8'hFF, 4'h0, 3'd0, 1'b1, 1'b1);
    push(54, "r_after54", 8'hFF, 4'h0, 3'd1, 1'b1, 1'b0);
    push(96, "r_after96", 8'hFF, 4'h0, 3'd0, 1'b1, 1'b1);
    drain();

    // Leading-zero handling (suppressed only when the feature is built in).
    do_reset();
    push(48,  "lz_d0",    8'hFE, 4'h5, 3'd0, 1'b1, 1'b1);
    push(54,  "lz_d1",    8'hFD, 4'h0, 3'd1, 1'b0, 1'b0);
    push(60,  "lz_d2",    8'hFB, 4'h3, 3'd2, 1'b0, 1'b0);
    push(66,  "lz_d3",    LZ ? 8'hFF : 8'hF7, 4'h0, 3'd3, 1'b0, 1'b0);
    push(90,  "lz_d7",    LZ ? 8'hFF : 8'h7F, 4'h0, 3'd7, 1'b0, 1'b0);
    push(96,  "lz0_d0",   8'hFE, 4'h0, 3'd0, 1'b1, 1'b1);
    push(102, "lz0_d1",   LZ ? 8'hFF : 8'hFD, 4'h0, 3'd1, 1'b1, 1'b0);
    write_at(5, 32'h0000_0305, 8'hFF);
    write_at(50, 32'h0000_0000, 8'hFF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

endmodule
